// File: rtl/out_sched_pkg.sv
// Shared constants and FSM encoding for the AES output scheduler.
package out_sched_pkg;

    localparam int unsigned BLK_W     = 128;
    localparam int unsigned BEAT_W    = 16;
    localparam int unsigned SER_BEATS = BLK_W / BEAT_W;

    typedef enum logic {
        IDLE  = 1'b0,
        BURST = 1'b1
    } state_e;

endpackage

// File: rtl/out_sched_if.sv
// Core-result and serializer-load signals of the output scheduler.
interface out_sched_if
    import out_sched_pkg::*;
#(
    parameter int unsigned DEPTH = 2
) ();

    localparam int unsigned CNT_W = $clog2(DEPTH + 1);

    logic             in_v;
    logic             in_t;
    logic [BLK_W-1:0] in_d;
    logic             in_rdy;
    logic             en;
    logic             so_vin;
    logic             so_tin;
    logic [BLK_W-1:0] so_din;
    logic [CNT_W-1:0] count;
    logic             busy;
    logic             ovf;

    // Driver side: AES core plus control.
    modport master (
        output in_v, in_t, in_d, en,
        input  in_rdy, so_vin, so_tin, so_din, count, busy, ovf
    );

    // Scheduler side.
    modport slave (
        input  in_v, in_t, in_d, en,
        output in_rdy, so_vin, so_tin, so_din, count, busy, ovf
    );

endinterface

// File: rtl/out_fifo.sv
// Small synchronous FIFO; head word is presented combinationally.
module out_fifo #(
    parameter int unsigned DEPTH = 2,
    parameter int unsigned WIDTH = 129
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         i_push,
    input  logic                         i_pop,
    input  logic [WIDTH-1:0]             i_data,
    output logic [WIDTH-1:0]             o_data,
    output logic                         o_full,
    output logic                         o_empty,
    output logic [$clog2(DEPTH+1)-1:0]   o_count
);

    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = $clog2(DEPTH + 1);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [PTR_W-1:0] r_wptr;
    logic [PTR_W-1:0] r_rptr;
    logic [CNT_W-1:0] r_count;
    logic             w_push;
    logic             w_pop;

    assign o_full  = (r_count == CNT_W'(DEPTH));
    assign o_empty = (r_count == '0);
    assign o_count = r_count;
    assign o_data  = r_mem[r_rptr];

    // Guard against pushing into a full or popping an empty FIFO.
    assign w_push = i_push & ~o_full;
    assign w_pop  = i_pop & ~o_empty;

    // Storage array; contents need no reset since count gates validity.
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wptr] <= i_data;
        end
    end

    // Pointers wrap naturally because DEPTH is a power of two.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
        end else begin
            if (w_push) begin
                r_wptr <= r_wptr + 1'b1;
            end
            if (w_pop) begin
                r_rptr <= r_rptr + 1'b1;
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

endmodule

// File: rtl/out_sched.sv
// Output scheduler: queues finished AES blocks and issues one serializer
// load per block, spaced BEATS cycles apart so bursts run back-to-back.
module out_sched
    import out_sched_pkg::*;
#(
    parameter int unsigned DEPTH = 2,
    parameter int unsigned BEATS = SER_BEATS
) (
    input  logic        clk,
    input  logic        rst,
    out_sched_if.slave  bus
);

    localparam int unsigned CNT_W  = $clog2(DEPTH + 1);
    localparam int unsigned BCNT_W = (BEATS > 1) ? $clog2(BEATS) : 1;

    state_e              r_state;
    logic [BCNT_W-1:0]   r_cnt;
    logic                r_so_vin;
    logic                r_so_tin;
    logic [BLK_W-1:0]    r_so_din;
    logic                r_ovf;

    logic                w_full;
    logic                w_empty;
    logic [CNT_W-1:0]    w_count;
    logic [BLK_W:0]      w_head;
    logic                w_push;
    logic                w_issue;

    // in_rdy looks at occupancy only, so a same-cycle pop never unblocks it.
    assign w_push  = bus.in_v & ~w_full;
    assign w_issue = ~w_empty & bus.en & ((r_state == IDLE) | (r_cnt == '0));

    out_fifo #(
        .DEPTH (DEPTH),
        .WIDTH (BLK_W + 1)
    ) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .i_push  (w_push),
        .i_pop   (w_issue),
        .i_data  ({bus.in_t, bus.in_d}),
        .o_data  (w_head),
        .o_full  (w_full),
        .o_empty (w_empty),
        .o_count (w_count)
    );

    assign bus.in_rdy = ~w_full;
    assign bus.so_vin = r_so_vin;
    assign bus.so_tin = r_so_tin;
    assign bus.so_din = r_so_din;
    assign bus.count  = w_count;
    assign bus.busy   = (r_state == BURST) | (w_count != '0);
    assign bus.ovf    = r_ovf;

    // Issue FSM, beat counter, registered serializer load and sticky overflow.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state  <= IDLE;
            r_cnt    <= '0;
            r_so_vin <= 1'b0;
            r_so_tin <= 1'b0;
            r_so_din <= '0;
            r_ovf    <= 1'b0;
        end else begin
            r_so_vin <= 1'b0;
            if (bus.in_v & w_full) begin
                r_ovf <= 1'b1;
            end
            if (w_issue) begin
                r_so_vin <= 1'b1;
                r_so_tin <= w_head[BLK_W];
                r_so_din <= w_head[BLK_W-1:0];
            end
            case (r_state)
                IDLE: begin
                    if (w_issue) begin
                        r_cnt   <= BCNT_W'(BEATS - 1);
                        r_state <= BURST;
                    end
                end
                BURST: begin
                    if (r_cnt != '0) begin
                        r_cnt <= r_cnt - 1'b1;
                    end else if (w_issue) begin
                        r_cnt <= BCNT_W'(BEATS - 1);
                    end else begin
                        r_state <= IDLE;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_out_sched.sv
// Directed bench for out_sched: latency, spacing, backpressure, overflow,
// enable gating, mid-burst reset and pointer wrap.
module tb_out_sched;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_total = 0;
    int   n_pass  = 0;

    out_sched_if #(.DEPTH(2)) bus ();

    out_sched #(
        .DEPTH (2),
        .BEATS (8)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    function automatic logic [127:0] gen(input int i);
        gen = {4{32'hC0DE0000 | 32'(i)}};
    endfunction

    initial begin
        logic [127:0] d0;
        int np;
        int ni;
        int last;
        bit acc;

        d0 = 128'h000102030405060708090a0b0c0d0e0f;
        bus.in_v = 1'b0;
        bus.in_t = 1'b0;
        bus.in_d = '0;
        bus.en   = 1'b1;

        // Reset values
        tick();
        tick();
        chk("rst_vin", bus.so_vin, 0);
        chk("rst_tin", bus.so_tin, 0);
        chk("rst_din", bus.so_din, 0);
        chk("rst_ovf", bus.ovf, 0);
        chk("rst_busy", bus.busy, 0);
        chk("rst_count", bus.count, 0);
        chk("rst_rdy", bus.in_rdy, 1);

        // Single block, cycle 0 = first cycle with rst low
        rst = 1'b0;
        bus.in_v = 1'b1;
        bus.in_t = 1'b1;
        bus.in_d = d0;
        tick();
        bus.in_v = 1'b0;
        chk("s_c1_vin", bus.so_vin, 0);
        chk("s_c1_count", bus.count, 1);
        chk("s_c1_busy", bus.busy, 1);
        tick();
        chk("s_c2_vin", bus.so_vin, 1);
        chk("s_c2_tin", bus.so_tin, 1);
        chk("s_c2_din", bus.so_din, d0);
        tick();
        chk("s_c3_vin", bus.so_vin, 0);
        chk("s_c3_din_hold", bus.so_din, d0);
        repeat (6) tick();
        chk("s_c9_busy", bus.busy, 1);
        tick();
        chk("s_c10_busy", bus.busy, 0);

        // Back-to-back A, B, C
        bus.in_v = 1'b1;
        bus.in_t = 1'b0;
        bus.in_d = gen(1);
        tick();
        bus.in_d = gen(2);
        tick();
        bus.in_d = gen(3);
        chk("b_c2_vin", bus.so_vin, 1);
        chk("b_c2_din", bus.so_din, gen(1));
        chk("b_c2_rdy", bus.in_rdy, 1);
        tick();
        bus.in_v = 1'b0;
        chk("b_c3_count", bus.count, 2);
        chk("b_c3_rdy", bus.in_rdy, 0);
        repeat (6) tick();
        chk("b_c9_vin", bus.so_vin, 0);
        tick();
        chk("b_c10_vin", bus.so_vin, 1);
        chk("b_c10_din", bus.so_din, gen(2));
        repeat (8) tick();
        chk("b_c18_vin", bus.so_vin, 1);
        chk("b_c18_din", bus.so_din, gen(3));
        chk("b_ovf", bus.ovf, 0);
        repeat (8) tick();
        chk("b_c26_busy", bus.busy, 0);

        // Overflow with en low
        bus.en   = 1'b0;
        bus.in_v = 1'b1;
        bus.in_d = gen(20);
        tick();
        bus.in_d = gen(21);
        tick();
        bus.in_d = gen(22);
        chk("o_c2_rdy", bus.in_rdy, 0);
        tick();
        bus.in_v = 1'b0;
        chk("o_c3_ovf", bus.ovf, 1);
        chk("o_c3_count", bus.count, 2);
        chk("o_c3_vin", bus.so_vin, 0);
        repeat (4) tick();
        chk("o_c7_ovf_sticky", bus.ovf, 1);
        chk("o_c7_count", bus.count, 2);
        bus.en = 1'b1;
        chk("o_c7_vin", bus.so_vin, 0);
        tick();
        chk("o_c8_vin", bus.so_vin, 1);
        chk("o_c8_din", bus.so_din, gen(20));
        repeat (8) tick();
        chk("o_c16_vin", bus.so_vin, 1);
        chk("o_c16_din", bus.so_din, gen(21));
        repeat (8) tick();
        chk("o_c24_vin", bus.so_vin, 0);
        chk("o_c24_count", bus.count, 0);
        chk("o_c24_busy", bus.busy, 0);
        chk("o_c24_ovf", bus.ovf, 1);

        // Enable gating mid-burst
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("e_ovf_cleared", bus.ovf, 0);
        bus.in_v = 1'b1;
        bus.in_d = gen(30);
        tick();
        bus.in_d = gen(31);
        tick();
        bus.in_v = 1'b0;
        chk("e_c2_vin", bus.so_vin, 1);
        chk("e_c2_din", bus.so_din, gen(30));
        repeat (3) tick();
        bus.en = 1'b0;
        repeat (5) tick();
        chk("e_c10_vin", bus.so_vin, 0);
        chk("e_c10_busy", bus.busy, 1);
        chk("e_c10_count", bus.count, 1);
        repeat (2) tick();
        bus.en = 1'b1;
        chk("e_c12_vin", bus.so_vin, 0);
        tick();
        chk("e_c13_vin", bus.so_vin, 1);
        chk("e_c13_din", bus.so_din, gen(31));
        repeat (8) tick();
        chk("e_c21_busy", bus.busy, 0);

        // Reset mid-burst with one block queued
        bus.in_v = 1'b1;
        bus.in_d = gen(40);
        tick();
        bus.in_d = gen(41);
        tick();
        bus.in_v = 1'b0;
        chk("r_c2_vin", bus.so_vin, 1);
        chk("r_c2_count", bus.count, 1);
        repeat (4) tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("r_count", bus.count, 0);
        chk("r_busy", bus.busy, 0);
        chk("r_vin", bus.so_vin, 0);
        chk("r_din", bus.so_din, 0);
        np = 0;
        repeat (12) begin
            tick();
            if (bus.so_vin) np++;
        end
        chk("r_no_issue", np, 0);

        // Stream 10 blocks through the wrapping FIFO
        np = 0;
        ni = 0;
        last = 0;
        for (int t = 0; t < 100; t++) begin
            if (bus.so_vin) begin
                chk("w_din", bus.so_din, gen(100 + np));
                chk("w_tin", bus.so_tin, 128'(np % 2));
                if (np > 0) chk("w_gap", t - last, 8);
                last = t;
                np++;
            end
            acc = (ni < 10) && bus.in_rdy;
            bus.in_v = acc;
            bus.in_d = gen(100 + ni);
            bus.in_t = 1'((ni % 2));
            tick();
            if (acc) ni++;
        end
        bus.in_v = 1'b0;
        chk("w_pulses", np, 10);
        chk("w_ovf", bus.ovf, 0);
        chk("w_busy", bus.busy, 0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
